// File: rtl/v7_peak_detector_if.sv
// Event port between the peak detector and the readout logic.
// The detector drives the event fields; the consumer drives peak_ready.
interface v7_peak_detector_if #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 32
);
  logic                     peak_valid;
  logic                     peak_ready;
  logic signed [DATA_W-1:0] peak_amp;
  logic [TS_W-1:0]          peak_ts;
  logic [7:0]               peak_width;
  logic                     peak_pileup;

  modport master (
    output peak_valid, peak_amp, peak_ts, peak_width, peak_pileup,
    input  peak_ready
  );

  modport slave (
    input  peak_valid, peak_amp, peak_ts, peak_width, peak_pileup,
    output peak_ready
  );
endinterface

// File: rtl/v7_peak_detector.sv
// Pulse peak detector: captures amplitude, timestamp and width of each pulse above
// THRESHOLD and offers it as one event on a valid/ready port.
//
// state       | meaning
// ST_IDLE     | armed, waiting for a sample above threshold
// ST_RISE     | inside a pulse, tracking max amplitude and width
// ST_HOLDOFF  | dead time after an emit, samples ignored
// ST_REARM    | waiting for a sample at/below threshold before re-arming
module v7_peak_detector #(
  parameter int                                SIZE_FILTER_DATA = 16,
  parameter logic signed [SIZE_FILTER_DATA-1:0] THRESHOLD        = 100,
  parameter int                                HOLDOFF          = 4,
  parameter int                                MAX_WIDTH        = 16,
  parameter int                                TS_WIDTH         = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
  v7_peak_detector_if.master                 peak,
  output logic [7:0]                         lost_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RISE,
    ST_HOLDOFF,
    ST_REARM
  } state_t;

  // A zero-length holdoff skips the dead-time state entirely.
  localparam state_t      ST_AFTER_EMIT = (HOLDOFF == 0) ? ST_REARM : ST_HOLDOFF;
  localparam logic [15:0] HOLD_LOAD     = 16'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [7:0]  MAX_W         = 8'(MAX_WIDTH);

  state_t                        state;
  logic [TS_WIDTH-1:0]           ts_cnt;
  logic [15:0]                   hold_cnt;
  logic signed [SIZE_FILTER_DATA-1:0] amp;
  logic [TS_WIDTH-1:0]           ts;
  logic [7:0]                    width;

  logic                          above;
  logic                          bigger;
  logic [7:0]                    width_inc;
  logic                          emit;
  logic signed [SIZE_FILTER_DATA-1:0] emit_amp;
  logic [TS_WIDTH-1:0]           emit_ts;
  logic [7:0]                    emit_width;
  logic                          emit_pileup;
  logic                          xfer;

  always_comb begin
    above       = filter_data > THRESHOLD;
    bigger      = filter_data > amp;
    width_inc   = width + 8'd1;
    emit        = 1'b0;
    emit_amp    = amp;
    emit_ts     = ts;
    emit_width  = width;
    emit_pileup = 1'b0;
    case (state)
      ST_IDLE: begin
        if (above && (MAX_W == 8'd1)) begin
          emit        = 1'b1;
          emit_amp    = filter_data;
          emit_ts     = ts_cnt;
          emit_width  = 8'd1;
          emit_pileup = 1'b1;
        end
      end
      ST_RISE: begin
        if (above) begin
          if (width_inc == MAX_W) begin
            emit        = 1'b1;
            emit_amp    = bigger ? filter_data : amp;
            emit_ts     = bigger ? ts_cnt : ts;
            emit_width  = width_inc;
            emit_pileup = 1'b1;
          end
        end else begin
          emit = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign xfer = peak.peak_valid & peak.peak_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      ts_cnt           <= '0;
      hold_cnt         <= '0;
      amp              <= '0;
      ts               <= '0;
      width            <= '0;
      peak.peak_valid  <= 1'b0;
      peak.peak_amp    <= '0;
      peak.peak_ts     <= '0;
      peak.peak_width  <= '0;
      peak.peak_pileup <= 1'b0;
      lost_count       <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (above) begin
            amp   <= filter_data;
            ts    <= ts_cnt;
            width <= 8'd1;
            if (emit) begin
              state    <= ST_AFTER_EMIT;
              hold_cnt <= HOLD_LOAD;
            end else begin
              state <= ST_RISE;
            end
          end
        end
        ST_RISE: begin
          if (above) begin
            width <= width_inc;
            if (bigger) begin
              amp <= filter_data;
              ts  <= ts_cnt;
            end
          end
          if (emit) begin
            state    <= ST_AFTER_EMIT;
            hold_cnt <= HOLD_LOAD;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt == 16'd0) state <= ST_REARM;
          else                   hold_cnt <= hold_cnt - 16'd1;
        end
        ST_REARM: begin
          if (!above) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A new emit may replace an event on the same edge it is accepted.
      if (emit && (!peak.peak_valid || xfer)) begin
        peak.peak_valid  <= 1'b1;
        peak.peak_amp    <= emit_amp;
        peak.peak_ts     <= emit_ts;
        peak.peak_width  <= emit_width;
        peak.peak_pileup <= emit_pileup;
      end else begin
        if (emit && lost_count != 8'hFF) lost_count <= lost_count + 8'd1;
        if (xfer) peak.peak_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_v7_peak_detector.sv
// Scoreboard bench for v7_peak_detector: tests push expected events, a monitor pops
// and compares them on every accepted transfer.
module tb_v7_peak_detector;
  localparam int DW  = 16;
  localparam int TSW = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic signed [DW-1:0] filter_data = '0;
  logic [7:0]           lost_count;

  v7_peak_detector_if #(.DATA_W(DW), .TS_W(TSW)) pk ();

  v7_peak_detector #(
    .SIZE_FILTER_DATA(DW),
    .THRESHOLD(16'sd100),
    .HOLDOFF(4),
    .MAX_WIDTH(16),
    .TS_WIDTH(TSW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .filter_data(filter_data),
    .peak(pk.master),
    .lost_count(lost_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] amp;
    logic [TSW-1:0]       ts;
    logic [7:0]           width;
    logic                 pileup;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  vectors      = 0;
  int  miscompares  = 0;
  int  valid_cycles = 0;

  // Transfer decided at the next posedge; inputs were set at this negedge.
  always @(negedge clk) begin
    #1;
    if (pk.peak_valid === 1'b1) valid_cycles++;
    if (pk.peak_valid === 1'b1 && pk.peak_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event got amp=%0d ts=%0d width=%0d pileup=%0b, required none",
                 pk.peak_amp, pk.peak_ts, pk.peak_width, pk.peak_pileup);
      end else begin
        mon_e = exp_q.pop_front();
        if (pk.peak_amp !== mon_e.amp || pk.peak_ts !== mon_e.ts ||
            pk.peak_width !== mon_e.width || pk.peak_pileup !== mon_e.pileup) begin
          miscompares++;
          $display("FAIL event got amp=%0d ts=%0d width=%0d pileup=%0b, required amp=%0d ts=%0d width=%0d pileup=%0b",
                   pk.peak_amp, pk.peak_ts, pk.peak_width, pk.peak_pileup,
                   mon_e.amp, mon_e.ts, mon_e.width, mon_e.pileup);
        end
      end
    end
  end

  task automatic push_ev(input int amp, input int ts, input int width, input logic pileup);
    ev_t e;
    e.amp    = DW'(amp);
    e.ts     = TSW'(ts);
    e.width  = 8'(width);
    e.pileup = pileup;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic signed [DW-1:0] s);
    filter_data = s;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    filter_data    = '0;
    pk.peak_ready  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    pk.peak_ready = 1'b1;
    filter_data   = 16'sd300;
    repeat (3) @(negedge clk);
    vectors++;
    if (pk.peak_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b required 0", pk.peak_valid); end
    vectors++;
    if (pk.peak_amp !== '0) begin miscompares++; $display("FAIL reset_amp got %0d required 0", pk.peak_amp); end
    vectors++;
    if (pk.peak_ts !== '0) begin miscompares++; $display("FAIL reset_ts got %0d required 0", pk.peak_ts); end
    vectors++;
    if (pk.peak_width !== 8'd0) begin miscompares++; $display("FAIL reset_width got %0d required 0", pk.peak_width); end
    vectors++;
    if (pk.peak_pileup !== 1'b0) begin miscompares++; $display("FAIL reset_pileup got %b required 0", pk.peak_pileup); end
    vectors++;
    if (lost_count !== 8'd0) begin miscompares++; $display("FAIL reset_lost got %0d required 0", lost_count); end
  endtask

  task automatic test_single_pulse();
    do_reset();
    valid_cycles = 0;
    push_ev(300, 3, 3, 1'b0);
    step(16'sd0); step(16'sd50); step(16'sd150); step(16'sd300); step(16'sd200); step(16'sd80);
    repeat (8) step(16'sd0);
    vectors++;
    if (valid_cycles !== 1) begin miscompares++; $display("FAIL single_valid_cycles got %0d required 1", valid_cycles); end
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL single_pending got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_tie();
    do_reset();
    repeat (10) step(16'sd0);
    push_ev(250, 11, 3, 1'b0);
    step(16'sd200); step(16'sd250); step(16'sd250); step(16'sd90);
    repeat (8) step(16'sd0);
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL tie_pending got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_pileup();
    do_reset();
    repeat (20) step(16'sd0);
    push_ev(200, 20, 16, 1'b1);
    repeat (40) step(16'sd200);
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL pileup_pending got %0d required 0", exp_q.size()); end
    step(16'sd50);
    push_ev(160, 62, 2, 1'b0);
    step(16'sd150); step(16'sd160); step(16'sd90);
    repeat (8) step(16'sd0);
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL rearm_pending got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_lost();
    do_reset();
    pk.peak_ready = 1'b0;
    push_ev(300, 1, 1, 1'b0);
    step(16'sd0); step(16'sd300); step(16'sd50);
    for (int i = 0; i < 5; i++) begin
      step(16'sd50);
      vectors++;
      if (pk.peak_valid !== 1'b1 || pk.peak_amp !== 16'sd300 || pk.peak_ts !== 32'd1) begin
        miscompares++;
        $display("FAIL held_event got valid=%b amp=%0d ts=%0d required valid=1 amp=300 ts=1",
                 pk.peak_valid, pk.peak_amp, pk.peak_ts);
      end
    end
    step(16'sd500); step(16'sd50);
    vectors++;
    if (lost_count !== 8'd1) begin miscompares++; $display("FAIL lost_count got %0d required 1", lost_count); end
    vectors++;
    if (pk.peak_amp !== 16'sd300) begin miscompares++; $display("FAIL held_after_drop got %0d required 300", pk.peak_amp); end
    pk.peak_ready = 1'b1;
    step(16'sd0);
    vectors++;
    if (pk.peak_valid !== 1'b0) begin miscompares++; $display("FAIL valid_after_xfer got %b required 0", pk.peak_valid); end
    repeat (4) step(16'sd0);
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL lost_pending got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_negative();
    do_reset();
    repeat (10) step(-16'sd500);
    vectors++;
    if (pk.peak_valid !== 1'b0) begin miscompares++; $display("FAIL negative_valid got %b required 0", pk.peak_valid); end
    push_ev(101, 10, 1, 1'b0);
    step(16'sd101);
    repeat (6) step(16'sd0);
    repeat (5) step(16'sd100);
    repeat (4) step(16'sd0);
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL threshold_pending got %0d required 0", exp_q.size()); end
    vectors++;
    if (lost_count !== 8'd0) begin miscompares++; $display("FAIL negative_lost got %0d required 0", lost_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(16'sd0); step(16'sd200); step(16'sd300);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (pk.peak_valid !== 1'b0 || pk.peak_amp !== '0 || pk.peak_ts !== '0 ||
        pk.peak_width !== 8'd0 || lost_count !== 8'd0) begin
      miscompares++;
      $display("FAIL async_reset got valid=%b amp=%0d ts=%0d width=%0d lost=%0d required all 0",
               pk.peak_valid, pk.peak_amp, pk.peak_ts, pk.peak_width, lost_count);
    end
    filter_data = 16'sd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) step(16'sd0);
    vectors++;
    if (pk.peak_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid got %b required 0", pk.peak_valid); end

    do_reset();
    push_ev(200, 1, 1, 1'b0);
    step(16'sd0); step(16'sd200); step(16'sd50); step(16'sd50);
    repeat (6) step(16'sd200);
    step(16'sd50); step(16'sd50);
    push_ev(120, 12, 1, 1'b0);
    step(16'sd120); step(16'sd50);
    repeat (8) step(16'sd0);
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL holdoff_pending got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    pk.peak_ready = 1'b1;
    test_reset();
    test_single_pulse();
    test_tie();
    test_pileup();
    test_lost();
    test_negative();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running required finished");
    $fatal(1, "watchdog");
  end
endmodule
